sha256_msg_reader: RTL and testbench



---
 rtl/sha256_msg_reader.sv | 176 +++++++++++++++++
 tb/tb_sha256_msg_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_reader.sv
// Reads a message from byte RAM, applies SHA-256 padding and streams big-endian 32-bit words.
// Optional build macro MSGRD_WORDCNT_EN adds a 16-bit count of accepted words.
module sha256_msg_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  msg_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_chipSel,
    output logic                  ram_wriEn,
    output logic                  ram_outEn,
    input  logic [7:0]            ram_data,
    output logic [31:0]           word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  block_first,
    output logic                  block_last,
    output logic                  busy,
    output logic                  done
`ifdef MSGRD_WORDCNT_EN
    ,
    output logic [15:0]           word_count
`endif
);

    // Byte indices run to T = L + up to 72, so two extra bits cover every length.
    localparam int IW = LEN_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_WAIT,
        RD_CAP,
        GEN,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [LEN_WIDTH-1:0] len_q;
    logic [IW-1:0]        byte_idx;
    logic [IW-1:0]        word_idx;
    logic [IW-1:0]        total;
    logic [31:0]          pack;
    logic                 done_q;

    logic [IW-1:0] len_ext;
    logic [IW-1:0] byte_next;
    logic [IW-1:0] total_start;
    logic [63:0]   bit_len;
    logic [7:0]    gen_byte;
    logic [7:0]    lane_byte;
    logic          word_full;
    logic          reading;
    logic          accept;
    logic          last_byte_out;

    assign len_ext       = IW'(len_q);
    assign byte_next     = byte_idx + IW'(1);
    assign word_full     = (byte_idx[1:0] == 2'd3);
    assign accept        = (state == EMIT) && word_ready;
    assign last_byte_out = (byte_idx == total);
    assign bit_len       = {{(61 - LEN_WIDTH){1'b0}}, len_q, 3'b000};
    assign total_start   = ((((IW'(msg_len) + IW'(8)) >> 6) + IW'(1)) << 6);

    // Generated bytes: 0x80 marker, zero fill, then the 64-bit bit length MSB first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gen_byte = 8'h00;
        if (byte_idx == len_ext) begin
            gen_byte = 8'h80;
        end else if (byte_idx >= total - IW'(8)) begin
            case (byte_idx[2:0])
                3'd0:    gen_byte = bit_len[63:56];
                3'd1:    gen_byte = bit_len[55:48];
                3'd2:    gen_byte = bit_len[47:40];
                3'd3:    gen_byte = bit_len[39:32];
                3'd4:    gen_byte = bit_len[31:24];
                3'd5:    gen_byte = bit_len[23:16];
                3'd6:    gen_byte = bit_len[15:8];
                default: gen_byte = bit_len[7:0];
            endcase
        end
    end

    assign lane_byte = (state == RD_CAP) ? ram_data : gen_byte;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (msg_len != '0) ? RD_ADDR : GEN;
            RD_ADDR: state_next = RD_WAIT;
            RD_WAIT: state_next = RD_CAP;
            RD_CAP: begin
                if (word_full)              state_next = EMIT;
                else if (byte_next < len_ext) state_next = RD_ADDR;
                else                        state_next = GEN;
            end
            GEN:     if (word_full) state_next = EMIT;
            EMIT: begin
                if (word_ready) begin
                    if (last_byte_out)           state_next = IDLE;
                    else if (byte_idx < len_ext) state_next = RD_ADDR;
                    else                         state_next = GEN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            byte_idx <= '0;
            word_idx <= '0;
            total    <= '0;
            pack     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= accept && last_byte_out;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= msg_len;
                        total    <= total_start;
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                RD_CAP, GEN: begin
                    // Lane 0 (byte_idx[1:0] == 0) lands in bits 31:24.
                    case (byte_idx[1:0])
                        2'd0:    pack[31:24] <= lane_byte;
                        2'd1:    pack[23:16] <= lane_byte;
                        2'd2:    pack[15:8]  <= lane_byte;
                        default: pack[7:0]   <= lane_byte;
                    endcase
                    byte_idx <= byte_next;
                end
                EMIT: if (word_ready) word_idx <= word_idx + IW'(1);
                default: ;
            endcase
        end
    end

`ifdef MSGRD_WORDCNT_EN
    always_ff @(posedge clk) begin
        if (rst)                        word_count <= '0;
        else if (state == IDLE && start) word_count <= '0;
        else if (accept)                word_count <= word_count + 16'd1;
    end
`endif

    assign reading     = (state == RD_ADDR) || (state == RD_WAIT) || (state == RD_CAP);
    assign ram_chipSel = reading;
    assign ram_outEn   = reading;
    assign ram_wriEn   = 1'b0;
    assign ram_addr    = reading ? byte_idx[ADDR_WIDTH-1:0] : '0;

    assign word_valid  = (state == EMIT);
    assign word_out    = word_valid ? pack : 32'h0;
    assign block_first = word_valid && (word_idx[3:0] == 4'd0);
    assign block_last  = word_valid && (word_idx == (total >> 2) - IW'(1));
    assign busy        = (state != IDLE) || done_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sha256_msg_reader.sv
// Directed bench for sha256_msg_reader: registered byte-RAM model, word capture, hand-computed vectors.
module tb_sha256_msg_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] msg_len;
    logic [9:0]  ram_addr;
    logic        ram_chipSel, ram_wriEn, ram_outEn;
    logic [7:0]  ram_data;
    logic [31:0] word_out;
    logic        word_valid, word_ready;
    logic        block_first, block_last, busy, done;
`ifdef MSGRD_WORDCNT_EN
    logic [15:0] word_count;
`endif

    sha256_msg_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .msg_len     (msg_len),
        .ram_addr    (ram_addr),
        .ram_chipSel (ram_chipSel),
        .ram_wriEn   (ram_wriEn),
        .ram_outEn   (ram_outEn),
        .ram_data    (ram_data),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .block_first (block_first),
        .block_last  (block_last),
        .busy        (busy),
        .done        (done)
`ifdef MSGRD_WORDCNT_EN
        ,
        .word_count  (word_count)
`endif
    );

    always #5 clk = ~clk;

    // Byte RAM with a registered read port.
    logic [7:0] mem [0:1023];
    logic [7:0] ram_q = 8'h00;
    int         strobes = 0;
    bit         wr_seen = 1'b0;

    always @(posedge clk) begin
        if (ram_chipSel && ram_outEn) begin
            ram_q   <= mem[ram_addr];
            strobes <= strobes + 1;
        end
        if (ram_wriEn) wr_seen <= 1'b1;
    end
    assign ram_data = ram_q;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] got   [64];
    bit          gf    [64];
    bit          gl    [64];
    logic [31:0] exp_w [64];
    int          nw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Starts one message and captures every accepted word; optional stall on word 0.
    task automatic run_msg(input string tag, input logic [15:0] len, input int stall);
        int cyc;
        bit fin;
        nw  = 0;
        fin = 1'b0;
        cyc = 0;
        @(negedge clk);
        start      = 1'b1;
        msg_len    = len;
        word_ready = (stall == 0);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        while (!fin && cyc < 5000) begin
            if (word_valid && !word_ready) begin
                for (int s = 0; s < stall; s++) begin
                    check($sformatf("%s_stall_valid_%0d", tag, s), 32'(word_valid), 32'd1);
                    check($sformatf("%s_stall_word_%0d", tag, s), word_out, 32'h00010280);
                    start   = (s == 1);
                    msg_len = (s == 1) ? 16'd7 : len;
                    @(negedge clk);
                end
                start      = 1'b0;
                msg_len    = len;
                word_ready = 1'b1;
            end
            if (word_valid && word_ready && nw < 64) begin
                got[nw] = word_out;
                gf[nw]  = block_first;
                gl[nw]  = block_last;
                nw++;
                if (block_last) fin = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd3);
        @(negedge clk);
        check({tag, "_idle_after_done"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic verify(input string tag, input int words);
        check({tag, "_nwords"}, nw, words);
        for (int k = 0; k < words && k < nw; k++) begin
            check($sformatf("%s_word%0d", tag, k), got[k], exp_w[k]);
            check($sformatf("%s_first%0d", tag, k), 32'(gf[k]), 32'(k % 16 == 0));
            check($sformatf("%s_last%0d", tag, k), 32'(gl[k]), 32'(k == words - 1));
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) exp_w[k] = 32'h0;
    endtask

    task automatic set_data_words();
        for (int k = 0; k < 7; k++) exp_w[k] = 32'h00010203 + k * 32'h04040404;
    endtask

    initial begin
        int s0;
        int cyc;
        for (int k = 0; k < 1024; k++) mem[k] = (k < 30) ? 8'(k) : 8'h00;
        rst        = 1'b1;
        start      = 1'b0;
        msg_len    = 16'd0;
        word_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {14'd0, ram_addr, ram_chipSel, ram_wriEn, ram_outEn,
                             word_valid, block_first, block_last, busy, done}, 32'd0);
        check("reset_word", word_out, 32'h0);
        rst = 1'b0;

        // L=3: one block, marker in word 0, bit length 24 in word 15.
        clear_exp();
        exp_w[0]  = 32'h00010280;
        exp_w[15] = 32'h00000018;
        s0 = strobes;
        run_msg("s1", 16'd3, 0);
        verify("s1", 16);
        check("s1_strobe_cycles", strobes - s0, 32'd9);

        // L=30: seven full data words, partial word with marker, length 240.
        clear_exp();
        set_data_words();
        exp_w[7]  = 32'h1C1D8000;
        exp_w[15] = 32'h000000F0;
        s0 = strobes;
        run_msg("s2", 16'd30, 0);
        verify("s2", 16);
        check("s2_strobe_cycles", strobes - s0, 32'd90);

        // L=56: length no longer fits, second block holds length 448.
        clear_exp();
        set_data_words();
        exp_w[7]  = 32'h1C1D0000;
        exp_w[14] = 32'h80000000;
        exp_w[31] = 32'h000001C0;
        s0 = strobes;
        run_msg("s3", 16'd56, 0);
        verify("s3", 32);
        check("s3_strobe_cycles", strobes - s0, 32'd168);

        // L=0: no RAM access, marker only.
        clear_exp();
        exp_w[0] = 32'h80000000;
        s0 = strobes;
        run_msg("s4", 16'd0, 0);
        verify("s4", 16);
        check("s4_strobe_cycles", strobes - s0, 32'd0);

        // L=3 with 5-cycle stall on word 0 and a stray start while busy.
        clear_exp();
        exp_w[0]  = 32'h00010280;
        exp_w[15] = 32'h00000018;
        run_msg("s5", 16'd3, 5);
        verify("s5", 16);

        // Reset while byte 10 of a 30-byte message is being read.
        word_ready = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        msg_len = 16'd30;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(ram_chipSel && ram_addr == 10'd10) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("s6_reached_byte10", {21'd0, ram_chipSel, ram_addr}, {21'd0, 1'b1, 10'd10});
        rst = 1'b1;
        @(negedge clk);
        check("s6_reset_ctrl", {14'd0, ram_addr, ram_chipSel, ram_wriEn, ram_outEn,
                                word_valid, block_first, block_last, busy, done}, 32'd0);
        check("s6_reset_word", word_out, 32'h0);
        rst = 1'b0;
        s0  = strobes;
        repeat (5) @(negedge clk);
        check("s6_no_access_after_reset", strobes - s0, 32'd0);
        check("s6_no_word_after_reset", {30'd0, word_valid, busy}, 32'd0);
        clear_exp();
        exp_w[0]  = 32'h00010280;
        exp_w[15] = 32'h00000018;
        run_msg("s6", 16'd3, 0);
        verify("s6", 16);

        check("never_write", 32'(wr_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
